// File: rtl/l1_refill_pkg.sv
// Shared types and constants for the L1 line-refill arbiter.
// Lines are 32-byte aligned, so the low LINE_OFF_BITS of every address are dropped.
package l1_refill_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  localparam int LINE_W_DEF    = 256;
  localparam int LINE_OFF_BITS = 5;

  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~((32'd1 << LINE_OFF_BITS) - 32'd1);
  endfunction

endpackage

// File: rtl/refill_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, and a tie goes to the
// side that was not granted last.
module refill_rr_pick
  import l1_refill_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  owner_e last_owner,
  output logic   grant_valid,
  output owner_e grant_owner
);

  always_comb begin
    grant_valid = req_i | req_d;
    grant_owner = OWN_I;
    if (req_i && req_d) begin
      grant_owner = (last_owner == OWN_D) ? OWN_I : OWN_D;
    end else if (req_d) begin
      grant_owner = OWN_D;
    end
  end

endmodule

// File: rtl/l1_refill_arbiter.sv
// Shares one line-refill port between the L1 I-cache and D-cache, one transaction
// at a time, with round-robin arbitration and a watchdog on the downstream ack.
module l1_refill_arbiter
  import l1_refill_pkg::*;
#(
  parameter int LINE_W         = LINE_W_DEF,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              immu_read,
  input  logic [31:0]       immu_addr,
  output logic              immu_done,
  output logic [LINE_W-1:0] immu_read_data,
  input  logic              dmmu_read,
  input  logic              dmmu_write,
  input  logic [31:0]       dmmu_addr,
  input  logic [LINE_W-1:0] dmmu_write_data,
  output logic              dmmu_done,
  output logic [LINE_W-1:0] dmmu_read_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              timeout_err
);

  // Handshake: each requester holds its request level-high until it sees a
  // one-cycle done; downstream holds mem_req until a one-cycle mem_ack.
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  owner_e            last_owner_q, last_owner_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              tmo_q, tmo_d;

  logic              grant_valid;
  owner_e            grant_owner;
  logic              fin;
  logic [LINE_W-1:0] fin_data;

  refill_rr_pick u_pick (
    .req_i       (immu_read),
    .req_d       (dmmu_read | dmmu_write),
    .last_owner  (last_owner_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    wd_d         = wd_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    tmo_d        = tmo_q;
    fin          = 1'b0;
    fin_data     = '0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          last_owner_d = grant_owner;
          wd_d         = '0;
          mem_req_d    = 1'b1;
          state_d      = BUSY;
          if (grant_owner == OWN_D) begin
            mem_addr_d  = line_align(dmmu_addr);
            mem_we_d    = dmmu_write;
            mem_wdata_d = dmmu_write ? dmmu_write_data : '0;
          end else begin
            mem_addr_d  = line_align(immu_addr);
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
          end
        end
      end
      BUSY: begin
        wd_d = wd_q + WD_W'(1);
        if (mem_ack) begin
          fin      = 1'b1;
          fin_data = mem_we_q ? '0 : mem_rdata;
        end else if (wd_q == WD_LAST) begin
          // Forced completion: owner gets zero data, ack arriving later is dropped.
          fin   = 1'b1;
          tmo_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fin) begin
      mem_req_d = 1'b0;
      state_d   = DONE;
      if (last_owner_q == OWN_D) begin
        d_done_d  = 1'b1;
        d_rdata_d = fin_data;
      end else begin
        i_done_d  = 1'b1;
        i_rdata_d = fin_data;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_D;
      wd_q         <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      wd_q         <= wd_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      tmo_q        <= tmo_d;
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign immu_done      = i_done_q;
  assign dmmu_done      = d_done_q;
  assign immu_read_data = i_rdata_q;
  assign dmmu_read_data = d_rdata_q;
  assign timeout_err    = tmo_q;

endmodule

// File: tb/tb_l1_refill_arbiter.sv
// Directed bench for l1_refill_arbiter with a short watchdog (8 cycles) so the
// timeout path is reachable; expected values are hand-derived per step.
`timescale 1ns/1ps
module tb_l1_refill_arbiter;

  localparam int LW = 256;

  logic          sys_clk = 1'b0;
  logic          rst;
  logic          immu_read;
  logic [31:0]   immu_addr;
  logic          immu_done;
  logic [LW-1:0] immu_read_data;
  logic          dmmu_read;
  logic          dmmu_write;
  logic [31:0]   dmmu_addr;
  logic [LW-1:0] dmmu_write_data;
  logic          dmmu_done;
  logic [LW-1:0] dmmu_read_data;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ack;
  logic [LW-1:0] mem_rdata;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  logic [LW-1:0] pat_a, pat_b, pat_c, wb_1, wb_2, wb_3;
  logic [LW-1:0] zero_line;

  always #5 sys_clk = ~sys_clk;

  l1_refill_arbiter #(.LINE_W(LW), .TIMEOUT_CYCLES(8)) dut (
    .sys_clk         (sys_clk),
    .rst             (rst),
    .immu_read       (immu_read),
    .immu_addr       (immu_addr),
    .immu_done       (immu_done),
    .immu_read_data  (immu_read_data),
    .dmmu_read       (dmmu_read),
    .dmmu_write      (dmmu_write),
    .dmmu_addr       (dmmu_addr),
    .dmmu_write_data (dmmu_write_data),
    .dmmu_done       (dmmu_done),
    .dmmu_read_data  (dmmu_read_data),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .timeout_err     (timeout_err)
  );

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle: inputs change and outputs are sampled 1ns after posedge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic ack_after(input int dly, input logic [LW-1:0] rd);
    repeat (dly) step();
    mem_ack   = 1'b1;
    mem_rdata = rd;
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    zero_line = '0;
    for (int i = 0; i < LW / 32; i++) begin
      pat_a[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
      pat_b[i*32 +: 32] = 32'hB00B_0000 ^ $urandom_range(1, 32'hFFFF);
      pat_c[i*32 +: 32] = 32'hC0DE_0000 + 32'(i * 3);
      wb_1[i*32 +: 32]  = 32'hD1D1_0000 + 32'(i);
      wb_2[i*32 +: 32]  = 32'hE2E2_0000 + 32'(i);
      wb_3[i*32 +: 32]  = 32'hF3F3_0000 + 32'(i);
    end

    rst = 1'b1; immu_read = 1'b0; immu_addr = '0;
    dmmu_read = 1'b0; dmmu_write = 1'b0; dmmu_addr = '0; dmmu_write_data = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, zero_line);
    chk("rst_i_done", immu_done, 1'b0);
    chk("rst_d_done", dmmu_done, 1'b0);
    chk("rst_i_data", immu_read_data, zero_line);
    chk("rst_d_data", dmmu_read_data, zero_line);
    chk("rst_tmo", timeout_err, 1'b0);
    rst = 1'b0;

    // I-only read, unaligned address
    immu_read = 1'b1; immu_addr = 32'h0000_1234;
    step();
    chk("i1_req", mem_req, 1'b1);
    chk("i1_addr", mem_addr, 32'h0000_1220);
    chk("i1_we", mem_we, 1'b0);
    ack_after(2, pat_a);
    chk("i1_done", immu_done, 1'b1);
    chk("i1_data", immu_read_data, pat_a);
    chk("i1_d_done", dmmu_done, 1'b0);
    chk("i1_req_drop", mem_req, 1'b0);
    immu_read = 1'b0;
    step();
    chk("i1_done_clear", immu_done, 1'b0);
    step();
    chk("i1_no_regrant", mem_req, 1'b0);
    chk("i1_data_hold", immu_read_data, pat_a);

    // Fresh reset so the tie-break starts from last_owner = D
    rst = 1'b1; step(); rst = 1'b0;
    immu_read = 1'b1; immu_addr = 32'h0000_0100;
    dmmu_write = 1'b1; dmmu_addr = 32'h0000_0200; dmmu_write_data = wb_1;
    step();
    chk("tie1_addr_i", mem_addr, 32'h0000_0100);
    chk("tie1_we_i", mem_we, 1'b0);
    ack_after(1, pat_b);
    chk("tie1_i_done", immu_done, 1'b1);
    chk("tie1_i_data", immu_read_data, pat_b);
    immu_read = 1'b0;
    step(); step();
    chk("tie1_req_d", mem_req, 1'b1);
    chk("tie1_addr_d", mem_addr, 32'h0000_0200);
    chk("tie1_we_d", mem_we, 1'b1);
    chk("tie1_wdata_d", mem_wdata, wb_1);
    ack_after(1, pat_c);
    chk("tie1_d_done", dmmu_done, 1'b1);
    chk("tie1_d_data_zero", dmmu_read_data, zero_line);
    chk("tie1_i_quiet", immu_done, 1'b0);
    dmmu_write = 1'b0;
    step(); step();

    // Second tie: alternation continues, I then D
    immu_read = 1'b1; immu_addr = 32'h0000_0140;
    dmmu_write = 1'b1; dmmu_addr = 32'h0000_0260; dmmu_write_data = wb_2;
    step();
    chk("tie2_addr_i", mem_addr, 32'h0000_0140);
    ack_after(0, pat_c);
    chk("tie2_i_data", immu_read_data, pat_c);
    immu_read = 1'b0;
    step(); step();
    chk("tie2_addr_d", mem_addr, 32'h0000_0260);
    chk("tie2_wdata_d", mem_wdata, wb_2);
    ack_after(0, pat_a);
    chk("tie2_d_done", dmmu_done, 1'b1);
    dmmu_write = 1'b0;
    step(); step();

    // D with read and write both high is a write
    dmmu_read = 1'b1; dmmu_write = 1'b1; dmmu_addr = 32'h0000_03FF; dmmu_write_data = wb_3;
    step();
    chk("rw_we", mem_we, 1'b1);
    chk("rw_addr", mem_addr, 32'h0000_03E0);
    chk("rw_wdata", mem_wdata, wb_3);
    ack_after(0, pat_a);
    chk("rw_done", dmmu_done, 1'b1);
    chk("rw_data_zero", dmmu_read_data, zero_line);
    dmmu_read = 1'b0; dmmu_write = 1'b0;
    step(); step();

    // D read returns line data
    dmmu_read = 1'b1; dmmu_addr = 32'h0000_0048;
    step();
    chk("dr_we", mem_we, 1'b0);
    chk("dr_addr", mem_addr, 32'h0000_0040);
    ack_after(1, pat_b);
    chk("dr_data", dmmu_read_data, pat_b);
    dmmu_read = 1'b0;
    step(); step();

    // Watchdog: no ack for 8 BUSY cycles
    immu_read = 1'b1; immu_addr = 32'h0000_0500;
    step();
    repeat (7) step();
    chk("wd_req_held", mem_req, 1'b1);
    chk("wd_tmo_pre", timeout_err, 1'b0);
    step();
    chk("wd_req_drop", mem_req, 1'b0);
    chk("wd_i_done", immu_done, 1'b1);
    chk("wd_i_data_zero", immu_read_data, zero_line);
    chk("wd_tmo", timeout_err, 1'b1);
    immu_read = 1'b0;
    mem_ack = 1'b1; mem_rdata = pat_a;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("late_i_done", immu_done, 1'b0);
    chk("late_d_done", dmmu_done, 1'b0);
    chk("late_i_data", immu_read_data, zero_line);
    step();
    chk("late_req", mem_req, 1'b0);
    chk("late_tmo_sticky", timeout_err, 1'b1);

    // Reset while BUSY, then normal regrant
    immu_read = 1'b1; immu_addr = 32'h0000_0600;
    step();
    chk("rb_req", mem_req, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rb_req_clear", mem_req, 1'b0);
    chk("rb_i_done", immu_done, 1'b0);
    chk("rb_tmo_clear", timeout_err, 1'b0);
    chk("rb_addr_clear", mem_addr, 32'h0);
    step();
    chk("rb_regrant", mem_req, 1'b1);
    chk("rb_regrant_addr", mem_addr, 32'h0000_0600);
    ack_after(0, pat_c);
    chk("rb_done", immu_done, 1'b1);

    // Request held through done: re-granted exactly once, at first IDLE cycle
    step();
    chk("hold_done_cycle", mem_req, 1'b0);
    step();
    chk("hold_regrant", mem_req, 1'b1);
    immu_read = 1'b0;
    ack_after(0, pat_a);
    chk("hold_done2", immu_done, 1'b1);
    chk("hold_data2", immu_read_data, pat_a);
    step(); step();
    chk("hold_once", mem_req, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
